ar_wr: RTL and testbench



---
 rtl/ar_wr_pkg.sv | 20 ++
 rtl/ar_wr_if.sv | 55 +++++
 rtl/ar_mem.sv | 60 ++++++
 rtl/ar_wr.sv | 103 ++++++++++
 tb/tb_ar_wr.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ar_wr_pkg.sv
// rtl/ar_wr_pkg.sv - shared geometry, fill value and state encoding for the byte array
//
// Purpose: single source for array geometry so the writer and the mux-style
// readers agree on entry width, depth and address width.
// Ports: none (package).

package ar_wr_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  localparam logic [DATA_W-1:0] INIT_VAL = DATA_W'(10);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } ar_state_e;

endpackage : ar_wr_pkg

// File: rtl/ar_wr_if.sv
// rtl/ar_wr_if.sv - write handshake and read port bundle for the byte array writer
//
// Purpose: groups the host write handshake, the clear request and the
// registered read port into one bundle.
// Signals:
//   clr       host -> array  level request to re-fill with INIT_VAL
//   wr_valid  host -> array  write request
//   wr_addr   host -> array  write entry index
//   wr_data   host -> array  write value
//   wr_ready  array -> host  write accepted this cycle when high with wr_valid
//   wr_ack    array -> host  one-cycle pulse after an accepted write
//   rd_addr   host -> array  read entry index
//   rd_data   array -> host  registered read data
//   init_done array -> host  array initialised and writable
// Modports: master (host side), slave (array side).

interface ar_wr_if
  import ar_wr_pkg::*;
();

  logic              clr;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              init_done;

  modport master (
    output clr,
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready,
    input  wr_ack,
    output rd_addr,
    input  rd_data,
    input  init_done
  );

  modport slave (
    input  clr,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready,
    output wr_ack,
    input  rd_addr,
    output rd_data,
    output init_done
  );

endinterface : ar_wr_if

// File: rtl/ar_mem.sv
// rtl/ar_mem.sv - DEPTH x DATA_W storage with one write port and a registered read port
//
// Purpose: holds the byte array. Contents are never reset; only the read
// register is. The read register forwards same-edge write data.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (read register only)
//   we_i       in   write enable
//   waddr_i    in   write index
//   wdata_i    in   write value
//   rd_addr_i  in   read index
//   rd_zero_i  in   force the read register to zero this edge
//   rd_data_o  out  registered read data

module ar_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_zero_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Write-through: a read of the entry being written returns the new value.
  always_comb begin
    rd_data_d = mem_q[rd_addr_i];
    if (rd_zero_i) begin
      rd_data_d = '0;
    end else if (we_i && (waddr_i == rd_addr_i)) begin
      rd_data_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : ar_mem

// File: rtl/ar_wr.sv
// rtl/ar_wr.sv - byte array writer: init fill, clear re-fill and addressed writes
//
// Purpose: after reset (or a clr request) fills all DEPTH entries with
// INIT_VAL, one per clock, then accepts addressed byte writes over a
// valid/ready handshake and exposes a registered read port.
// Ports:
//   clk    in       rising-edge clock
//   rst_n  in       asynchronous active-low reset
//   bus    slave    ar_wr_if bundle (clr, write handshake, read port, init_done)

module ar_wr
  import ar_wr_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  ar_wr_if.slave   bus
);

  ar_state_e         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_ack_q;
  logic              init_done_q;

  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // A clear request blocks any same-cycle write so it cannot be acked and
  // then immediately overwritten by the fill.
  assign bus.wr_ready = (state_q == S_RUN) && !bus.clr;
  assign wr_accept    = bus.wr_valid && bus.wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      wr_ack_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          wr_ack_q <= 1'b0;
          // idx wraps to 0 on the last fill write, ready for the next clr.
          idx_q    <= idx_q + 1'b1;
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          wr_ack_q <= wr_accept;
          if (bus.clr) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_INIT;
          idx_q       <= '0;
          wr_ack_q    <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // The fill owns the write port while in S_INIT; host writes only in S_RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = INIT_VAL;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // Reads return zero on every edge where the array is not yet initialised,
  // including the edge that completes the fill.
  ar_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .rd_addr_i (bus.rd_addr),
    .rd_zero_i (!init_done_q),
    .rd_data_o (bus.rd_data)
  );

  assign bus.wr_ack    = wr_ack_q;
  assign bus.init_done = init_done_q;

endmodule : ar_wr

// File: tb/tb_ar_wr.sv
// tb/tb_ar_wr.sv - directed self-checking bench for ar_wr

module tb_ar_wr;

  import ar_wr_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ar_wr_if bus ();

  ar_wr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fill sequence from a state where the fill has just begun (edge 0 done or
  // reset just released): 8 edges with init_done low until the 8th.
  task automatic test_init_fill(input string tag);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (bus.init_done !== (e == 8)) begin
        errors++;
        $display("FAIL %s init_done edge %0d: got %b want %b", tag, e, bus.init_done, (e == 8));
      end
      checks++;
      if (bus.wr_ready !== (e == 8)) begin
        errors++;
        $display("FAIL %s wr_ready edge %0d: got %b want %b", tag, e, bus.wr_ready, (e == 8));
      end
      checks++;
      if (bus.rd_data !== 8'h00) begin
        errors++;
        $display("FAIL %s rd_data during fill edge %0d: got %h want 00", tag, e, bus.rd_data);
      end
      checks++;
      if (bus.wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL %s wr_ack during fill edge %0d: got %b want 0", tag, e, bus.wr_ack);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset wr_ack: got %b want 0", bus.wr_ack);
    end
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset rd_data: got %h want 00", bus.rd_data);
    end
    checks++;
    if (bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset init_done: got %b want 0", bus.init_done);
    end
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset wr_ready: got %b want 0", bus.wr_ready);
    end
    rst_n = 1'b1;
    test_init_fill("power_on");
  endtask

  task automatic test_read_all_init(input string tag);
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      @(negedge clk);
      checks++;
      if (bus.rd_data !== 8'd10) begin
        errors++;
        $display("FAIL %s read addr %0d: got %h want 0a", tag, a, bus.rd_data);
      end
    end
  endtask

  task automatic test_single_write;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd3;
    bus.wr_data  = 8'hA5;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL single wr_ready: got %b want 1", bus.wr_ready);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL single wr_ack pulse: got %b want 1", bus.wr_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL single wr_ack drop: got %b want 0", bus.wr_ack);
    end
    bus.rd_addr = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL single read addr3: got %h want a5", bus.rd_data);
    end
    bus.rd_addr = 3'd2;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 8'd10) begin
      errors++;
      $display("FAIL single read addr2: got %h want 0a", bus.rd_data);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 3'(i);
      bus.wr_data  = 8'(i);
      @(negedge clk);
      checks++;
      if (bus.wr_ack !== 1'b1) begin
        errors++;
        $display("FAIL b2b wr_ack cycle %0d: got %b want 1", i, bus.wr_ack);
      end
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b wr_ack after burst: got %b want 0", bus.wr_ack);
    end
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      @(negedge clk);
      checks++;
      if (bus.rd_data !== 8'(a)) begin
        errors++;
        $display("FAIL b2b read addr %0d: got %h want %h", a, bus.rd_data, 8'(a));
      end
    end
  endtask

  task automatic test_write_through;
    bus.rd_addr  = 3'd5;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd5;
    bus.wr_data  = 8'h3C;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL write_through rd_data: got %h want 3c", bus.rd_data);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL write_through stored: got %h want 3c", bus.rd_data);
    end
  endtask

  task automatic test_clr;
    bus.clr      = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd1;
    bus.wr_data  = 8'hFF;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr wr_ready: got %b want 0", bus.wr_ready);
    end
    @(negedge clk);
    bus.clr      = 1'b0;
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL clr wr_ack: got %b want 0", bus.wr_ack);
    end
    checks++;
    if (bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL clr init_done: got %b want 0", bus.init_done);
    end
    test_init_fill("clr");
    test_read_all_init("clr");
  endtask

  task automatic test_reset_mid;
    // Async reset while wr_ack and rd_data are non-zero.
    bus.rd_addr  = 3'd6;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd6;
    bus.wr_data  = 8'h77;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.rd_data !== 8'h77) begin
      errors++;
      $display("FAIL pre_reset state: got ack=%b data=%h want ack=1 data=77", bus.wr_ack, bus.rd_data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_ack !== 1'b0 || bus.rd_data !== 8'h00 || bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL async reset mid_write: got ack=%b data=%h done=%b want 0/00/0",
               bus.wr_ack, bus.rd_data, bus.init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Three fill edges, then reset inside the 4th init cycle.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.init_done !== 1'b0 || bus.wr_ready !== 1'b0 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL async reset mid_init: got done=%b ready=%b data=%h want 0/0/00",
               bus.init_done, bus.wr_ready, bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_init_fill("reset_mid_init");
    test_read_all_init("reset_mid_init");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr  = '0;

    test_reset();
    test_read_all_init("power_on");
    test_single_write();
    test_back_to_back();
    test_write_through();
    test_clr();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ar_wr
